dmem_resp: RTL and testbench
============================

// Module: dmem_resp
// PURPOSE
// - Data-memory responder: the memory end of the core's load/store request channel (valid/wen/addr/wdata/wmask).
// - Accepts one request at a time, holds it for a fixed access latency, then returns read data or a write ack.
// - Word-organised register-array storage; lets the core's load/store path run in RTL without DPI pmem calls.
// PARAMETERS
// - DEPTH     1024         number of 32-bit words; power of two, >= 4
// - BASE      32'h80000000 byte address of word 0
// - LAT       2            cycles from accept to o_rsp_valid, >= 1
// PORTS
// - i_clk        in   1   clock, all state on rising edge
// - i_rst_n      in   1   reset, asynchronous assert, active-low
// - i_req_valid  in   1   request present
// - o_req_ready  out  1   responder can accept a request
// - i_req_wen    in   1   1 = store, 0 = load
// - i_req_addr   in   32  byte address
// - i_req_wdata  in   32  store data
// - i_req_wmask  in   4   store byte enables, bit k -> wdata[8k+7:8k]
// - o_rsp_valid  out  1   response present
// - i_rsp_ready  in   1   core accepts response
// - o_rsp_rdata  out  32  load data (0 for stores and errors)
// - o_rsp_err    out  1   access fault for this response
// BEHAVIOUR
// - Reset (i_rst_n=0, async): state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, counter=0.
//   Memory array contents are NOT reset. Reset mid-access drops the request; a pending store is not written.
// - FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: o_req_ready=1; i_req_valid&o_req_ready = accept: latch wen/addr/wdata/wmask, load counter=LAT-1,
//         go WAIT (LAT>1) or directly RESP (LAT=1).
//   WAIT: o_req_ready=0; counter decrements each cycle; at counter==0 go RESP next cycle.
//   RESP: o_rsp_valid=1, outputs held stable until i_rsp_ready=1; on handshake -> IDLE.
// - Latency: response valid exactly LAT cycles after the accept edge when no back-pressure.
// - o_req_ready is a registered state decode; never depends combinationally on i_req_valid.
// - One outstanding request only; no new accept in the handshake cycle of RESP (IDLE first: max 1 req / LAT+1 cycles).
// - Address check at accept: idx=(addr-BASE)>>2 (32-bit wrap arithmetic).
//   Fault if addr[1:0]!=0 or (addr-BASE) >= DEPTH*4 (unsigned). Faulting request: no array access,
//   response with o_rsp_err=1, o_rsp_rdata=0, same latency.
// - Store: on entry to RESP, mem[idx] bytes with wmask bit set take wdata bytes; others unchanged. wmask=0 -> no change,
//   still acked. o_rsp_rdata=0 for stores.
// - Load: o_rsp_rdata=mem[idx] sampled on entry to RESP; i_req_wmask ignored.
// - Store then load to the same word: load returns the stored bytes (store completes before its own response).
// - Request inputs ignored outside IDLE; response outputs are 0 whenever o_rsp_valid=0.
// CONFIGURATION
// - DMEM_RESP_RAND_LAT_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle;
//   at accept, lfsr[1:0] extra wait cycles (0..3) are added, total latency LAT..LAT+3. Stresses core stall logic.
// - Not defined: latency exactly LAT; no LFSR logic present.
// TESTING
// - Store 32'hDEADBEEF to BASE, wmask 4'hF, then load BASE -> rsp after LAT cycles each, rdata=32'hDEADBEEF, err=0.
// - Load BASE+4 after store 32'h11223344 with wmask 4'b0101 over old 32'hFFFFFFFF -> rdata=32'hFF22FF44.
// - Load BASE+2 (misaligned) and BASE+DEPTH*4 -> err=1, rdata=0, array unchanged on readback.
// - Hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid/rdata stable, o_req_ready=0; accept resumes after handshake.
// - Assert i_rst_n=0 during WAIT of a store to BASE+8 -> outputs at reset values immediately; later load shows old value.
// - With DMEM_RESP_RAND_LAT_EN: 200 random loads/stores vs reference model -> data match, latency in [LAT,LAT+3].

Source files
------------

// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// dmem_resp_if : load/store request channel between core (master) and memory
// Revision     : 1.0
// ============================================================================
interface dmem_resp_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_wen;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [3:0]  i_req_wmask;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;

   modport slave (
      input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport master (
      output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// dmem_resp : single-outstanding data-memory responder with fixed access latency
//             DMEM_RESP_RAND_LAT_EN adds 0..3 LFSR-chosen extra wait cycles
// Revision  : 1.0
// ============================================================================
module dmem_resp #(
   parameter int          DEPTH = 1024,
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int          LAT   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   dmem_resp_if.slave bus
);
   localparam int          c_IDX_W = $clog2(DEPTH);
   localparam int          c_CNT_W = $clog2(LAT + 4);
   localparam logic [32:0] c_SPAN  = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic                 r_wen;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [3:0]           r_wmask;
   logic [31:0]          r_rdata;
   logic                 r_err;
   logic [31:0]          r_mem [DEPTH];

   logic                 w_idle;
   logic                 w_cur_wen;
   logic [31:0]          w_cur_addr;
   logic [31:0]          w_cur_wdata;
   logic [3:0]           w_cur_wmask;
   logic [31:0]          w_off;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_fault;
   logic                 w_enter_resp;
   logic                 w_do_write;
   logic [c_CNT_W-1:0]   w_extra;
   logic [c_CNT_W-1:0]   w_load;

   assign w_idle = (r_state == ST_IDLE);

   // With LAT=1 the array is touched on the accept edge itself, so the live
   // request is used while idle and the latched copy afterwards.
   assign w_cur_wen   = w_idle ? bus.i_req_wen   : r_wen;
   assign w_cur_addr  = w_idle ? bus.i_req_addr  : r_addr;
   assign w_cur_wdata = w_idle ? bus.i_req_wdata : r_wdata;
   assign w_cur_wmask = w_idle ? bus.i_req_wmask : r_wmask;

   assign w_off   = w_cur_addr - BASE;
   assign w_idx   = w_off[c_IDX_W+1:2];
   assign w_fault = (w_cur_addr[1:0] != 2'b00) || ({1'b0, w_off} >= c_SPAN);

   assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
   assign w_do_write   = w_enter_resp && w_cur_wen && !w_fault && i_rst_n;

`ifdef DMEM_RESP_RAND_LAT_EN
   logic [7:0] r_lfsr;

   // Fibonacci form of x^8+x^6+x^5+x^4+1
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_extra = c_CNT_W'(r_lfsr[1:0]);
`else
   assign w_extra = '0;
`endif

   assign w_load = c_CNT_W'(LAT - 1) + w_extra;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_req_valid) begin
               w_cnt_nxt   = w_load;
               w_state_nxt = (w_load == '0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
            if (r_cnt <= c_CNT_W'(1)) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.i_rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_idle && bus.i_req_valid) begin
            r_wen   <= bus.i_req_wen;
            r_addr  <= bus.i_req_addr;
            r_wdata <= bus.i_req_wdata;
            r_wmask <= bus.i_req_wmask;
         end
         if (w_enter_resp) begin
            r_err   <= w_fault;
            r_rdata <= (w_cur_wen || w_fault) ? 32'h0 : r_mem[w_idx];
         end else if ((r_state == ST_RESP) && bus.i_rsp_ready) begin
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (w_do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_cur_wmask[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.o_req_ready = (r_state == ST_IDLE);
   assign bus.o_rsp_valid = (r_state == ST_RESP);
   assign bus.o_rsp_rdata = r_rdata;
   assign bus.o_rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// tb_dmem_resp : directed bench for dmem_resp with a word-map reference model
// Revision     : 1.0
// ============================================================================
module tb_dmem_resp;
   localparam int          c_DEPTH = 1024;
   localparam logic [31:0] c_BASE  = 32'h8000_0000;
   localparam int          c_LAT   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_resp_if bus ();

   dmem_resp #(.DEPTH(c_DEPTH), .BASE(c_BASE), .LAT(c_LAT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int acc_count = 0;
   int hs_count = 0;

   // Reference model: word index -> contents, only for words the bench wrote
   logic [31:0] mdl [int];

   logic        p_pend = 1'b0;
   logic        p_seen = 1'b0;
   logic        p_wen, p_err, p_known;
   logic [31:0] p_addr, p_wdata, p_rdata;
   logic [3:0]  p_wmask;
   int          p_acc;
   logic [31:0] last_rdata;
   logic        last_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_fault(input logic [31:0] a);
      logic [31:0] off;
      off = a - c_BASE;
      return (a[1:0] != 2'b00) || (off >= 32'(c_DEPTH * 4));
   endfunction

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - c_BASE;
      return int'(off >> 2);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
         chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
         chk("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
         chk("rst_rsp_err",   32'(bus.o_rsp_err), 32'd0);
         p_pend = 1'b0;
      end else begin
         chk("req_ready", 32'(bus.o_req_ready), 32'(!p_pend));
         if (bus.o_rsp_valid) begin
            if (!p_pend) begin
               chk("unexpected_rsp", 32'(bus.o_rsp_valid), 32'd0);
            end else begin
               if (p_known) chk("rsp_rdata", bus.o_rsp_rdata, p_rdata);
               chk("rsp_err", 32'(bus.o_rsp_err), 32'(p_err));
               if (!p_seen) begin
`ifdef DMEM_RESP_RAND_LAT_EN
                  chk("latency_in_range",
                      32'((cyc + 1 - p_acc) >= c_LAT && (cyc + 1 - p_acc) <= c_LAT + 3), 32'd1);
`else
                  chk("latency", 32'(cyc + 1 - p_acc), 32'(c_LAT));
`endif
                  p_seen = 1'b1;
               end
               if (bus.i_rsp_ready) begin
                  last_rdata = bus.o_rsp_rdata;
                  last_err   = bus.o_rsp_err;
                  if (p_wen && !p_err) begin
                     logic [31:0] w;
                     w = mdl.exists(word_of(p_addr)) ? mdl[word_of(p_addr)] : 32'h0;
                     for (int b = 0; b < 4; b++)
                        if (p_wmask[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
                     // bytes never written stay unknown unless the whole word is covered
                     if (mdl.exists(word_of(p_addr)) || p_wmask == 4'hF) mdl[word_of(p_addr)] = w;
                  end
                  p_pend = 1'b0;
                  hs_count++;
               end
            end
         end else begin
            chk("idle_rdata", bus.o_rsp_rdata, 32'd0);
            chk("idle_err",   32'(bus.o_rsp_err), 32'd0);
         end
         if (bus.i_req_valid && bus.o_req_ready) begin
            p_pend  = 1'b1;
            p_seen  = 1'b0;
            p_acc   = cyc + 1;
            p_wen   = bus.i_req_wen;
            p_addr  = bus.i_req_addr;
            p_wdata = bus.i_req_wdata;
            p_wmask = bus.i_req_wmask;
            p_err   = is_fault(bus.i_req_addr);
            p_known = p_wen || p_err || mdl.exists(word_of(p_addr));
            p_rdata = (p_wen || p_err || !p_known) ? 32'h0 : mdl[word_of(p_addr)];
            acc_count++;
         end
      end
   end

   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input int hold);
      int a0, h0, n;
      a0 = acc_count;
      h0 = hs_count;
      bus.i_req_valid = 1'b1;
      bus.i_req_wen   = wen;
      bus.i_req_addr  = addr;
      bus.i_req_wdata = wdata;
      bus.i_req_wmask = wmask;
      bus.i_rsp_ready = (hold == 0);
      n = 0;
      while (acc_count == a0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      if (acc_count == a0) chk("accept_timeout", 32'd0, 32'd1);
      #2;
      // Garbage on the request side must be ignored while busy
      bus.i_req_valid = 1'b0;
      bus.i_req_wen   = ~wen;
      bus.i_req_addr  = ~addr;
      bus.i_req_wdata = ~wdata;
      bus.i_req_wmask = ~wmask;
      if (hold > 0) begin
         n = 0;
         while (!p_seen && n < 20) begin
            @(posedge clk);
            n++;
         end
         repeat (hold) @(posedge clk);
         #2 bus.i_rsp_ready = 1'b1;
      end
      n = 0;
      while (hs_count == h0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (hs_count == h0) chk("rsp_timeout", 32'd0, 32'd1);
      #2;
   endtask

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_wen   = 1'b0;
      bus.i_req_addr  = '0;
      bus.i_req_wdata = '0;
      bus.i_req_wmask = '0;
      bus.i_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;

      do_req(1'b1, c_BASE, 32'hDEADBEEF, 4'hF, 0);
      chk("store_ack_err", 32'(last_err), 32'd0);
      chk("store_ack_rdata", last_rdata, 32'd0);
      do_req(1'b0, c_BASE, 32'h0, 4'h0, 0);
      chk("load_base", last_rdata, 32'hDEADBEEF);

      do_req(1'b1, c_BASE + 32'd4, 32'hFFFFFFFF, 4'hF, 0);
      do_req(1'b1, c_BASE + 32'd4, 32'h11223344, 4'b0101, 0);
      do_req(1'b0, c_BASE + 32'd4, 32'h0, 4'hF, 0);
      chk("load_partial", last_rdata, 32'hFF22FF44);
      chk("model_partial", mdl[1], 32'hFF22FF44);

      do_req(1'b0, c_BASE + 32'd2, 32'h0, 4'h0, 0);
      chk("misalign_err", 32'(last_err), 32'd1);
      chk("misalign_rdata", last_rdata, 32'd0);
      do_req(1'b0, c_BASE + 32'(c_DEPTH * 4), 32'h0, 4'h0, 0);
      chk("oob_err", 32'(last_err), 32'd1);
      do_req(1'b1, c_BASE + 32'd1, 32'h0, 4'hF, 0);
      chk("misalign_store_err", 32'(last_err), 32'd1);
      do_req(1'b1, c_BASE - 32'd4, 32'h0, 4'hF, 0);
      chk("below_base_err", 32'(last_err), 32'd1);
      do_req(1'b0, c_BASE, 32'h0, 4'h0, 0);
      chk("base_unchanged", last_rdata, 32'hDEADBEEF);

      do_req(1'b1, c_BASE, 32'hCAFEF00D, 4'h0, 0);
      chk("nomask_ack_err", 32'(last_err), 32'd0);
      do_req(1'b0, c_BASE, 32'h0, 4'h0, 0);
      chk("nomask_unchanged", last_rdata, 32'hDEADBEEF);

      do_req(1'b1, c_BASE + 32'(c_DEPTH * 4 - 4), 32'hAABBCCDD, 4'hF, 0);
      do_req(1'b1, c_BASE + 32'(c_DEPTH * 4 - 4), 32'h12345678, 4'b1000, 0);
      do_req(1'b0, c_BASE + 32'(c_DEPTH * 4 - 4), 32'h0, 4'h0, 0);
      chk("last_word", last_rdata, 32'h12BBCCDD);

      do_req(1'b0, c_BASE + 32'd4, 32'h0, 4'h0, 5);
      chk("backpressure_load", last_rdata, 32'hFF22FF44);
      do_req(1'b0, c_BASE, 32'h0, 4'h0, 0);
      chk("after_backpressure", last_rdata, 32'hDEADBEEF);

      // Reset while a store sits in WAIT: it must never reach the array
      do_req(1'b1, c_BASE + 32'd8, 32'hAABBCCDD, 4'hF, 0);
      bus.i_req_valid = 1'b1;
      bus.i_req_wen   = 1'b1;
      bus.i_req_addr  = c_BASE + 32'd8;
      bus.i_req_wdata = 32'h00000000;
      bus.i_req_wmask = 4'hF;
      @(posedge clk);
      #2;
      bus.i_req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ready", 32'(bus.o_req_ready), 32'd1);
      chk("async_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
      chk("async_rst_rdata", bus.o_rsp_rdata, 32'd0);
      chk("async_rst_err",   32'(bus.o_rsp_err), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      do_req(1'b0, c_BASE + 32'd8, 32'h0, 4'h0, 0);
      chk("dropped_store", last_rdata, 32'hAABBCCDD);

`ifdef DMEM_RESP_RAND_LAT_EN
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         a = c_BASE + 32'($urandom_range(0, 7) * 4);
         if ($urandom_range(0, 15) == 0) a = a + 32'd2;
         do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)));
      end
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
`default_nettype wire
